// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package regfile_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } arb_state_e;

   localparam int NREQ_DEF     = 4;
   localparam int ADDR_W_DEF   = 16;
   localparam int DATA_W_DEF   = 8;
   localparam int DEPTH_DEF    = 16;
   localparam int MAX_LOCK_DEF = 4;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshake bundle plus the register-file write port driven by the arbiter.
interface regfile_wr_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        lock;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        ack;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   busy;
   logic                   err;

   modport master (
      output req, lock, req_addr, req_data,
      input  ack, wr_en, wr_addr, wr_data, busy, err
   );

   modport slave (
      input  req, lock, req_addr, req_data,
      output ack, wr_en, wr_addr, wr_data, busy, err
   );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic             any
);

   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx] && !found) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter with burst lock for the 16x8 register file.
// Optional address range check: define REGFILE_ARB_ADDR_CHECK_EN.
//
// state    | meaning
// ST_IDLE  | sample requests, pick winner, latch its addr/data
// ST_WRITE | wr_en/ack pulse for the winner; advance ptr and lock count
module regfile_wr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wr_arbiter_if.slave bus
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
`ifdef REGFILE_ARB_ADDR_CHECK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif

   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              own_lock_q, own_lock_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              wr_en_q, wr_en_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [NREQ-1:0]   rr_grant;
   logic              rr_any;
   logic [PTR_W-1:0]  rr_idx, win;
   logic              keep_owner, in_range;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .grant (rr_grant),
      .any   (rr_any)
   );

   always_comb begin
      rr_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (rr_grant[i]) rr_idx = PTR_W'(i);
   end

   assign keep_owner = own_lock_q && bus.req[owner_q] && (lock_cnt_q < CNT_W'(MAX_LOCK));
   assign win        = keep_owner ? owner_q : rr_idx;
   assign win_addr   = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
   assign win_data   = bus.req_data[int'(win)*DATA_W +: DATA_W];
   assign in_range   = (32'(win_addr) < 32'(DEPTH));

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      own_lock_d = own_lock_q;
      ack_d      = '0;
      wr_en_d    = 1'b0;
      busy_d     = 1'b0;
      err_d      = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (rr_any) begin
               state_d    = ST_WRITE;
               busy_d     = 1'b1;
               ack_d[win] = 1'b1;
               wr_en_d    = !ADDR_CHK || in_range;
               err_d      = ADDR_CHK && !in_range;
               wr_addr_d  = win_addr;
               wr_data_d  = win_data;
               owner_d    = win;
               own_lock_d = bus.lock[win];
               // an exhausted burst loses priority and restarts its count
               if (lock_cnt_q >= CNT_W'(MAX_LOCK)) lock_cnt_d = '0;
            end
         end
         ST_WRITE: begin
            state_d    = ST_IDLE;
            ptr_d      = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            lock_cnt_d = own_lock_q ? lock_cnt_q + 1'b1 : '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         own_lock_q <= 1'b0;
         ack_q      <= '0;
         wr_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         own_lock_q <= own_lock_d;
         ack_q      <= ack_d;
         wr_en_q    <= wr_en_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign bus.ack     = ack_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;

endmodule
